// File: rtl/paint_bus_arbiter_pkg.sv
// Shared types and sizing for the paint-path bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Requester indices: 0 = cursor, 1 = palette, 2 = control.
package paint_bus_arbiter_pkg;

    localparam int N_REQ = 3;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam int REQ_CURSOR  = 0;
    localparam int REQ_PALETA  = 1;
    localparam int REQ_CONTROL = 2;

    typedef logic [IW-1:0] req_idx_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // One pixel write as presented to the framebuffer writer.
    typedef struct packed {
        logic [AW-1:0] x;
        logic [AW-1:0] y;
        logic [DW-1:0] data;
    } px_wr_t;

    // Pulls one requester's write fields out of the packed input buses.
    function automatic px_wr_t slice_wr(input logic [N_REQ*AW-1:0] xs,
                                        input logic [N_REQ*AW-1:0] ys,
                                        input logic [N_REQ*DW-1:0] ds,
                                        input req_idx_t            idx);
        px_wr_t r;
        r = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_idx_t'(i) == idx) begin
                r.x    = xs[i*AW +: AW];
                r.y    = ys[i*AW +: AW];
                r.data = ds[i*DW +: DW];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/paint_bus_arbiter_if.sv
// Pixel-write bus between paint requesters and the arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req until gnt; wr without gnt is dropped.
//
// master: requester side (drives req/wr/coords/data, sees gnt and the forwarded write)
// slave : arbiter side
interface paint_bus_arbiter_if;
    import paint_bus_arbiter_pkg::*;

    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    wr;
    logic [N_REQ*AW-1:0] x_in;
    logic [N_REQ*AW-1:0] y_in;
    logic [N_REQ*DW-1:0] data_in;

    logic [N_REQ-1:0]    gnt;
    logic [AW-1:0]       out_x;
    logic [AW-1:0]       out_y;
    logic [DW-1:0]       px_data;
    logic                paint;
    logic                busy;

    modport master (
        output req, wr, x_in, y_in, data_in,
        input  gnt, out_x, out_y, px_data, paint, busy
    );

    modport slave (
        input  req, wr, x_in, y_in, data_in,
        output gnt, out_x, out_y, px_data, paint, busy
    );

endinterface

// File: rtl/paint_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req after 'last', with wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; sel is all-zero when no req is set.
//
// Ports: req (request vector), last (previous owner) -> sel (one-hot), idx (its index).
module paint_bus_arbiter_rr_pick
    import paint_bus_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         last,
    output logic [N_REQ-1:0] sel,
    output req_idx_t         idx
);

    always_comb begin
        logic     found;
        req_idx_t cand;
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // Scan last+1 .. last+N_REQ, so the previous owner is checked last.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = req_idx_t'((int'(last) + k) % N_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                sel[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/paint_bus_arbiter.sv
// Round-robin arbiter for the framebuffer pixel-write bus, with burst limit.
// Latency: req->gnt 1 cycle; wr->paint/out_* 1 cycle (registered).
// Backpressure: losers keep req high and wait; wr from a non-owner is dropped.
//
// Ports: clk, rst (async, active-low), bus (slave modport: req/wr/x_in/y_in/data_in
// in; gnt/out_x/out_y/px_data/paint/busy out). MAX_BURST = grant cycles allowed while
// someone else waits (0 = unlimited).
module paint_bus_arbiter
    import paint_bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 64
) (
    input  logic                clk,
    input  logic                rst,
    paint_bus_arbiter_if.slave  bus
);

    localparam int            CW         = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [CW-1:0] BURST_SAT  = CW'(MAX_BURST);
    localparam logic [CW-1:0] BURST_LAST = (MAX_BURST > 0) ? CW'(MAX_BURST - 1) : '0;

    state_t           state_q,     state_d;
    logic [N_REQ-1:0] gnt_q,       gnt_d;
    req_idx_t         owner_q,     owner_d;
    req_idx_t         last_q,      last_d;
    logic [CW-1:0]    burst_cnt_q, burst_cnt_d;
    px_wr_t           out_q,       out_d;
    logic             paint_q,     paint_d;
    logic             busy_q,      busy_d;

    logic [N_REQ-1:0] pick_sel;
    req_idx_t         pick_idx;
    px_wr_t           owner_wr;
    logic             others_pending;
    logic             release_now;

    paint_bus_arbiter_rr_pick u_rr_pick (
        .req  (bus.req),
        .last (last_q),
        .sel  (pick_sel),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        owner_d        = owner_q;
        last_d         = last_q;
        burst_cnt_d    = burst_cnt_q;
        out_d          = out_q;
        paint_d        = 1'b0;
        busy_d         = busy_q;
        release_now    = 1'b0;
        owner_wr       = slice_wr(bus.x_in, bus.y_in, bus.data_in, owner_q);
        others_pending = |(bus.req & ~gnt_q);

        case (state_q)
            ST_IDLE: begin
                // gnt is already low here, so every grant is preceded by >=1 dead cycle.
                if (|bus.req) begin
                    state_d     = ST_GRANT;
                    gnt_d       = pick_sel;
                    owner_d     = pick_idx;
                    busy_d      = 1'b1;
                    burst_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (bus.wr[owner_q]) begin
                    out_d   = owner_wr;
                    paint_d = 1'b1;
                end
                if (burst_cnt_q != BURST_SAT) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                // A lone owner is never cut off; preemption needs a waiting requester.
                release_now = !bus.req[owner_q] ||
                              ((MAX_BURST != 0) && (burst_cnt_q == BURST_LAST) && others_pending);
                if (release_now) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    last_d  = owner_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            last_q      <= req_idx_t'(N_REQ - 1);
            burst_cnt_q <= '0;
            out_q       <= '0;
            paint_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            out_q       <= out_d;
            paint_q     <= paint_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.out_x   = out_q.x;
    assign bus.out_y   = out_q.y;
    assign bus.px_data = out_q.data;
    assign bus.paint   = paint_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_paint_bus_arbiter.sv
// Bench for paint_bus_arbiter: scoreboard fed by a behavioural model of the arbitration rules.
// Latency: n/a.
// Backpressure: n/a.
module tb_paint_bus_arbiter;
    import paint_bus_arbiter_pkg::*;

    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    paint_bus_arbiter_if bus ();

    paint_bus_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int gnt;
        int busy;
        int paint;
        int x;
        int y;
        int d;
    } st_exp_t;

    typedef struct {
        int x;
        int y;
        int d;
    } wr_exp_t;

    st_exp_t exp_q[$];
    wr_exp_t wrq[$];

    int checks = 0;
    int errors = 0;

    // Stimulus values for each requester, applied at the next cycle() call.
    int sx[N_REQ];
    int sy[N_REQ];
    int sd[N_REQ];

    // Reference model: who owns the bus, who owned it last, how long it has been held.
    int m_owner = -1;
    int m_last  = N_REQ - 1;
    int m_held  = 0;
    int m_x = 0, m_y = 0, m_d = 0, m_paint = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N_REQ - 1;
        m_held  = 0;
        m_x = 0; m_y = 0; m_d = 0; m_paint = 0;
    endtask

    // Advance the model by one clock edge given this cycle's req/wr; push what the DUT should show.
    task automatic model_step(input int r, input int w);
        st_exp_t e;
        if (m_owner < 0) begin
            m_paint = 0;
            if (r != 0) begin
                for (int k = 1; k <= N_REQ; k++) begin
                    int c;
                    c = (m_last + k) % N_REQ;
                    if (((r >> c) & 1) != 0) begin
                        m_owner = c;
                        break;
                    end
                end
                m_held = 0;
            end
        end else begin
            int o;
            int others;
            o      = m_owner;
            others = r & ~(1 << o);
            if (((w >> o) & 1) != 0) begin
                m_x = sx[o]; m_y = sy[o]; m_d = sd[o];
                m_paint = 1;
                wrq.push_back('{x: m_x, y: m_y, d: m_d});
            end else begin
                m_paint = 0;
            end
            if (((r >> o) & 1) == 0 || (MAXB != 0 && m_held == MAXB - 1 && others != 0)) begin
                m_last  = o;
                m_owner = -1;
            end
            m_held = (m_held + 1 > MAXB) ? MAXB : m_held + 1;
        end
        e.gnt   = (m_owner < 0) ? 0 : (1 << m_owner);
        e.busy  = (m_owner < 0) ? 0 : 1;
        e.paint = m_paint;
        e.x = m_x; e.y = m_y; e.d = m_d;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge and record the expected result.
    task automatic cycle(input int r, input int w);
        logic [N_REQ*AW-1:0] xs, ys;
        logic [N_REQ*DW-1:0] ds;
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++) begin
            xs[i*AW +: AW] = AW'(sx[i]);
            ys[i*AW +: AW] = AW'(sy[i]);
            ds[i*DW +: DW] = DW'(sd[i]);
        end
        bus.req     = N_REQ'(r);
        bus.wr      = N_REQ'(w);
        bus.x_in    = xs;
        bus.y_in    = ys;
        bus.data_in = ds;
        model_step(r, w);
    endtask

    task automatic set_req(input int i, input int x, input int y, input int d);
        sx[i] = x; sy[i] = y; sd[i] = d;
    endtask

    // Monitor: one expected status per stimulated edge, one expected write per paint pulse.
    always begin
        st_exp_t e;
        wr_exp_t wx;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gnt",     int'(bus.gnt),     e.gnt);
            chk("busy",    int'(bus.busy),    e.busy);
            chk("paint",   int'(bus.paint),   e.paint);
            chk("out_x",   int'(bus.out_x),   e.x);
            chk("out_y",   int'(bus.out_y),   e.y);
            chk("px_data", int'(bus.px_data), e.d);
        end
        if (bus.paint === 1'b1) begin
            if (wrq.size() == 0) begin
                chk("paint_unexpected", 1, 0);
            end else begin
                wx = wrq.pop_front();
                chk("wr_x", int'(bus.out_x),   wx.x);
                chk("wr_y", int'(bus.out_y),   wx.y);
                chk("wr_d", int'(bus.px_data), wx.d);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int rr;
        bus.req = '0; bus.wr = '0; bus.x_in = '0; bus.y_in = '0; bus.data_in = '0;
        for (int i = 0; i < N_REQ; i++) set_req(i, 0, 0, 0);
        rst = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",   int'(bus.gnt),     0);
        chk("rst_busy",  int'(bus.busy),    0);
        chk("rst_paint", int'(bus.paint),   0);
        chk("rst_x",     int'(bus.out_x),   0);
        chk("rst_y",     int'(bus.out_y),   0);
        chk("rst_d",     int'(bus.px_data), 0);
        @(negedge clk);
        rst = 1'b1;

        // Single cursor burst: four writes of (5,7,A5).
        set_req(0, 5, 7, 'hA5);
        cycle(1, 0);
        repeat (4) cycle(1, 1);
        cycle(0, 0);
        cycle(0, 0);

        // Non-owner writes are dropped while cursor holds the bus.
        set_req(0, 9, 10, 'h11);
        set_req(1, 33, 34, 'h77);
        cycle(1, 0);
        cycle(1, 2);
        cycle(1, 2);
        cycle(1, 3);
        cycle(0, 2);
        cycle(0, 0);

        // Burst limit: cursor held, control waiting -> preempted after MAXB grant cycles.
        set_req(0, 1, 2, 'h10);
        set_req(2, 61, 62, 'hC3);
        cycle(1, 0);
        repeat (7) cycle(5, 5);
        repeat (4) cycle(1, 5);
        cycle(0, 0);
        cycle(0, 0);

        // Lone palette requester held far past MAXB: never preempted.
        repeat (200) begin
            set_req(1, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 255));
            cycle(2, $urandom_range(0, 7));
        end
        cycle(0, 0);
        cycle(0, 0);

        // Reset mid-burst while paint is high.
        set_req(2, 40, 41, 'h5A);
        cycle(4, 0);
        cycle(4, 4);
        cycle(4, 4);
        @(posedge clk);
        #3;
        rst = 1'b0;
        bus.req = '0;
        bus.wr  = '0;
        #1;
        chk("arst_gnt",   int'(bus.gnt),     0);
        chk("arst_paint", int'(bus.paint),   0);
        chk("arst_busy",  int'(bus.busy),    0);
        chk("arst_x",     int'(bus.out_x),   0);
        chk("arst_y",     int'(bus.out_y),   0);
        chk("arst_d",     int'(bus.px_data), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // All three rise together after reset: order 0,1,2, each dropping after two writes.
        set_req(0, 3, 4, 'h01);
        set_req(1, 13, 14, 'h02);
        set_req(2, 23, 24, 'h03);
        cycle(7, 0);
        cycle(7, 7);
        cycle(7, 7);
        cycle(6, 0);
        cycle(6, 0);
        cycle(6, 7);
        cycle(6, 7);
        cycle(4, 0);
        cycle(4, 0);
        cycle(4, 7);
        cycle(4, 7);
        cycle(0, 0);
        cycle(0, 0);

        // Random contention with slowly changing request levels.
        rr = 0;
        repeat (1500) begin
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom_range(0, 11) == 0) rr = rr ^ (1 << i);
                set_req(i, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 255));
            end
            cycle(rr, $urandom_range(0, 7));
        end
        cycle(0, 0);
        cycle(0, 0);
        cycle(0, 0);

        @(posedge clk);
        #2;
        chk("status_q_drained", exp_q.size(), 0);
        chk("write_q_drained",  wrq.size(),   0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
